spi_slave_port: RTL and testbench
=================================

# spi_slave_port

SPI responder (slave) endpoint that sits on the far side of the team's Wishbone-to-SPI master, in the same clock domain. It is used as a bench companion and as a peripheral front-end. It deserialises MOSI into bytes delivered on a valid/ready receive port. It serialises bytes taken from a valid/ready transmit port onto MISO, timed to match the master's capture point one SCK rising edge later. There is no chip select, so frames are delimited by bit count plus an idle timeout.

## Interface
- IDLE_TIMEOUT, 8: number of wb_clk cycles without an SCK rising edge, mid-frame, that aborts the frame.
- FILL_BYTE, 8'hFF: byte shifted out when no transmit byte is buffered at frame start.
- wb_clk  in  1  clock; sck, mosi and miso are all synchronous to it; no synchronisers.
- wb_rst  in  1  reset, asynchronous, active-low.
- sck  in  1  serial clock from master; idles low (mode 0).
- mosi  in  1  master out, MSB first.
- miso  out  1  slave out, registered.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-entry transmit buffer is empty.
- rx_data  out  8  last received byte; held while rx_valid is high.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  frame in progress (bit_cnt != 0).
- underrun  out  1  one-cycle pulse: FILL_BYTE was used for a frame.
- overrun  out  1  one-cycle pulse: a received byte was dropped.
- frame_err  out  1  one-cycle pulse: idle timeout aborted a partial frame.

## Operation
- sck_q is sck registered each cycle. rise = sck & ~sck_q. Falling edges are ignored.
- States: IDLE (bit_cnt=0) and SHIFT (bit_cnt 1..7).
- Rise in IDLE:
  - tx_src = tx_buf if the buffer is full (the buffer is consumed); otherwise tx_src = FILL_BYTE and underrun pulses.
  - miso <= tx_src[7]; tx_shift <= tx_src<<1.
  - rx_shift <= {7'b0,mosi}; bit_cnt <= 1.
- Rise in SHIFT:
  - rx_shift <= {rx_shift[6:0],mosi}; miso <= tx_shift[7]; tx_shift <= tx_shift<<1; bit_cnt++.
- On the 8th rise: bit_cnt <= 0, and the assembled byte {rx_shift[6:0],mosi} is pushed to the receive holding register.
- Receive push:
  - If rx_valid=0, or rx_ready=1 in the same cycle: rx_data <= byte, rx_valid <= 1.
  - Otherwise the new byte is dropped, rx_data is kept, and overrun pulses.
- rx_valid clears the cycle after rx_valid & rx_ready, unless a push happens in that same cycle.
- Transmit buffer:
  - Written on tx_valid & tx_ready.
  - tx_ready = ~tx_full.
  - A buffer load and a consume in the same cycle cannot collide: consume only happens when the buffer is full, and then tx_ready=0.
- Timeout: idle_cnt resets on every rise and counts while in SHIFT. When it reaches IDLE_TIMEOUT, the partial byte is discarded, bit_cnt <= 0, miso <= 0, and frame_err pulses.
- Reset mid-frame: all state returns to reset values; any partial byte is lost.

## Timing
- Reset values:
  - miso 0, tx_ready 1, rx_valid 0, rx_data 8'h00.
  - busy, underrun, overrun and frame_err all 0.
  - sck_q 0, bit_cnt 0, idle_cnt 0.
- A rise is detected in the cycle after the master's SCK-high edge, while mosi is still stable. mosi is sampled at the end of that cycle.
- MISO bit 7-(k-1) is valid from the clock edge after rise k.
  - The master samples it at its next SCK-high edge; bit 0 is sampled in the master's final state.
  - The minimum SCK period is therefore 2 wb_clk.
- rx_valid rises 1 cycle after the 8th rise is detected.
- A tx byte written at least 1 cycle before the first rise of a frame is used for that frame.
- The master's 18-cycle transfer yields exactly one byte and no frame_err, provided IDLE_TIMEOUT ≥ 3.

## Structure
- Shared package spi_pkg holds:
  - SPI_BITS = 8.
  - The state enum {SPI_IDLE, SPI_SHIFT}.
  - Default FILL_BYTE.
- idle_cnt width is $clog2(IDLE_TIMEOUT+1).
- One natural sub-module: spi_byte_hold, a one-entry valid/ready register. It is instantiated twice: once as the tx buffer and once as the rx holding register with drop-on-full (overrun).

## Test plan
- tx 8'hA5 preloaded; master sends 8'h3C → rx_data=8'h3C with rx_valid=1; master reads 8'hA5; underrun=0.
- No tx preload; master sends 8'h81 → master reads 8'hFF; underrun pulses once; rx_data=8'h81.
- Two frames (8'h11, 8'h22) with rx_ready=0 → rx_data stays 8'h11; overrun pulses once on frame 2. Repeat with rx_ready=1 in the push cycle → rx_data=8'h22 and no overrun.
- 3 SCK pulses, then SCK held low for 8 cycles → frame_err pulses at cycle 8; busy→0; the next full frame 8'h5A is received correctly.
- wb_rst asserted after bit 4 → miso=0, rx_valid=0, tx_ready=1 immediately. After release, frame 8'hC3 is received intact.
- Back-to-back frames with tx 8'h01 and 8'h02 refilled between them → master reads 8'h01, then 8'h02; tx_ready toggles 0→1 at each first rise.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder port.
// Imported by the byte holding register and the top.
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam logic [7:0] SPI_FILL_DEF = 8'hFF;

  typedef enum logic {
    SPI_IDLE,
    SPI_SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_byte_hold.sv
// One-entry valid/ready holding register.
// BYPASS lets a pop and a push share a cycle.
module spi_byte_hold #(
  parameter int W      = 8,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = BYPASS ? (~valid_q | out_ready) : ~valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (out_ready) valid_d = 1'b0;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/spi_slave_port.sv
// Mode-0 SPI responder without chip select.
// Frames end on bit count or on an SCK idle timeout.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int         IDLE_TIMEOUT = 8,
  parameter logic [7:0] FILL_BYTE    = SPI_FILL_DEF
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       underrun,
  output logic       overrun,
  output logic       frame_err
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] TO_V = IW'(IDLE_TIMEOUT);
  localparam logic [2:0] LAST = 3'(SPI_BITS - 1);

  spi_state_e  state_q, state_d;
  logic        sck_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  logic        miso_q, miso_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic        underrun_q, underrun_d;
  logic        overrun_q, overrun_d;
  logic        ferr_q, ferr_d;

  logic        rise;
  logic        tx_full, tx_take;
  logic [7:0]  tx_buf, tx_src;
  logic        rx_push, rx_acc;
  logic [7:0]  rx_byte;

  assign rise     = sck & ~sck_q;
  assign tx_src   = tx_full ? tx_buf : FILL_BYTE;
  assign rx_byte  = {rx_shift_q, mosi};
  assign idle_inc = idle_q + IW'(1);

  spi_byte_hold #(.W(8), .BYPASS(1'b0)) u_tx_hold (
    .clk      (wb_clk),
    .rst_n    (wb_rst),
    .in_valid (tx_valid),
    .in_data  (tx_data),
    .in_ready (tx_ready),
    .out_valid(tx_full),
    .out_data (tx_buf),
    .out_ready(tx_take)
  );

  spi_byte_hold #(.W(8), .BYPASS(1'b1)) u_rx_hold (
    .clk      (wb_clk),
    .rst_n    (wb_rst),
    .in_valid (rx_push),
    .in_data  (rx_byte),
    .in_ready (rx_acc),
    .out_valid(rx_valid),
    .out_data (rx_data),
    .out_ready(rx_ready)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idle_d     = idle_q;
    miso_d     = miso_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    underrun_d = 1'b0;
    ferr_d     = 1'b0;
    tx_take    = 1'b0;
    rx_push    = 1'b0;
    unique case (state_q)
      SPI_IDLE: begin
        idle_d = '0;
        if (rise) begin
          tx_take    = tx_full;
          underrun_d = ~tx_full;
          miso_d     = tx_src[7];
          tx_shift_d = {tx_src[6:0], 1'b0};
          rx_shift_d = {6'b0, mosi};
          bit_cnt_d  = 3'd1;
          state_d    = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (rise) begin
          idle_d     = '0;
          rx_shift_d = {rx_shift_q[5:0], mosi};
          miso_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST) begin
            rx_push = 1'b1;
            state_d = SPI_IDLE;
          end
        end else if (idle_inc == TO_V) begin
          // master stalled: drop the partial byte
          idle_d    = '0;
          bit_cnt_d = 3'd0;
          miso_d    = 1'b0;
          ferr_d    = 1'b1;
          state_d   = SPI_IDLE;
        end else begin
          idle_d = idle_inc;
        end
      end
    endcase
    overrun_d = rx_push & ~rx_acc;
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q    <= SPI_IDLE;
      sck_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      idle_q     <= '0;
      miso_q     <= 1'b0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 7'h00;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck;
      bit_cnt_q  <= bit_cnt_d;
      idle_q     <= idle_d;
      miso_q     <= miso_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign miso      = miso_q;
  assign busy      = (state_q == SPI_SHIFT);
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Random and directed frames against a byte-level
// model of the transmit buffer and receive register.
module tb_spi_slave_port;

  localparam int TO = 8;
  localparam logic [7:0] FILL = 8'hFF;

  logic wb_clk = 1'b0;
  logic wb_rst, sck, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ready;
  logic busy, underrun, overrun, frame_err;

  int checks = 0;
  int failures = 0;
  int n_under = 0, n_over = 0, n_ferr = 0;
  int e_under = 0, e_over = 0, e_ferr = 0;

  bit m_full = 0;
  logic [7:0] m_tx = 8'h00;
  bit m_rxv = 0;
  logic [7:0] m_rxd = 8'h00;

  always #5 wb_clk = ~wb_clk;

  spi_slave_port #(.IDLE_TIMEOUT(TO), .FILL_BYTE(FILL)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .underrun (underrun),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always @(negedge wb_clk) begin
    n_under <= n_under + int'(underrun);
    n_over  <= n_over + int'(overrun);
    n_ferr  <= n_ferr + int'(frame_err);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_load(input logic [7:0] b);
    @(negedge wb_clk);
    chk("tx_ready_pre", tx_ready, !m_full);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge wb_clk);
    tx_valid = 1'b0;
    if (!m_full) begin
      m_full = 1;
      m_tx   = b;
    end
    chk("tx_ready_post", tx_ready, 0);
  endtask

  task automatic pop();
    @(negedge wb_clk);
    rx_ready = 1'b1;
    @(negedge wb_clk);
    rx_ready = 1'b0;
    m_rxv = 0;
    chk("rx_valid_pop", rx_valid, 0);
  endtask

  task automatic frame(input logic [7:0] mo, input int nbits,
                       input bit rdy_push, input bit do_rst);
    logic [7:0] exp_mi;
    logic [7:0] mi;
    mi = 8'h00;
    if (m_full) begin
      exp_mi = m_tx;
      m_full = 0;
    end else begin
      exp_mi = FILL;
      e_under++;
    end
    for (int k = 0; k < nbits; k++) begin
      @(negedge wb_clk);
      sck  = 1'b1;
      mosi = mo[7-k];
      if (k == 7 && rdy_push) rx_ready = 1'b1;
      @(negedge wb_clk);
      sck = 1'b0;
      rx_ready = 1'b0;
      mi[7-k] = miso;
      if (k == 0) chk("tx_ready_rise1", tx_ready, 1);
    end
    if (nbits == 8) begin
      chk("miso_byte", mi, exp_mi);
      if (m_rxv && !rdy_push) e_over++;
      else begin
        m_rxv = 1;
        m_rxd = mo;
      end
      chk("rx_valid", rx_valid, m_rxv);
      chk("rx_data", rx_data, m_rxd);
      chk("busy_end", busy, 0);
    end else if (do_rst) begin
      chk("busy_mid", busy, 1);
      @(negedge wb_clk);
      wb_rst = 1'b0;
      #1;
      chk("rst_miso", miso, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rx_data", rx_data, 0);
      m_full = 0;
      m_rxv  = 0;
      m_rxd  = 8'h00;
      @(negedge wb_clk);
      wb_rst = 1'b1;
    end else begin
      chk("miso_part", mi >> (8 - nbits),
          exp_mi >> (8 - nbits));
      repeat (TO - 1) @(negedge wb_clk);
      chk("busy_before_to", busy, 1);
      @(negedge wb_clk);
      chk("busy_after_to", busy, 0);
      chk("frame_err_pulse", frame_err, 1);
      chk("miso_after_to", miso, 0);
      e_ferr++;
      repeat (2) @(negedge wb_clk);
      chk("rx_valid_to", rx_valid, m_rxv);
    end
    @(negedge wb_clk);
    @(negedge wb_clk);
    chk("n_underrun", n_under, e_under);
    chk("n_overrun", n_over, e_over);
    chk("n_frame_err", n_ferr, e_ferr);
  endtask

  initial begin
    int nb;
    bit rp, rs;
    wb_rst = 1'b0;
    sck = 1'b0;
    mosi = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    rx_ready = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk("rst_miso0", miso, 0);
    chk("rst_tx_ready0", tx_ready, 1);
    chk("rst_rx_valid0", rx_valid, 0);
    chk("rst_rx_data0", rx_data, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_pulses0",
        {underrun, overrun, frame_err}, 0);
    wb_rst = 1'b1;

    tx_load(8'hA5);
    frame(8'h3C, 8, 0, 0);
    pop();
    frame(8'h81, 8, 0, 0);
    pop();
    frame(8'h11, 8, 0, 0);
    frame(8'h22, 8, 0, 0);
    pop();
    frame(8'h11, 8, 0, 0);
    frame(8'h22, 8, 1, 0);
    pop();
    frame(8'h00, 3, 0, 0);
    frame(8'h5A, 8, 0, 0);
    pop();
    tx_load(8'h77);
    frame(8'hC3, 4, 0, 1);
    frame(8'hC3, 8, 0, 0);
    pop();
    tx_load(8'h01);
    frame(8'h10, 8, 1, 0);
    tx_load(8'h02);
    frame(8'h20, 8, 1, 0);
    pop();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        tx_load(8'($urandom));
      if ($urandom_range(0, 1) == 1)
        tx_load(8'($urandom));
      if ($urandom_range(0, 2) == 0) pop();
      nb = ($urandom_range(0, 5) == 0) ?
           $urandom_range(1, 7) : 8;
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 2) == 0);
      frame(8'($urandom), nb, rp, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
